// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - op encoding, expected truth tables and sweep state encoding
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;

    // Truth tables indexed by {in1,in2}, so bit 3 is the (1,1) response.
    localparam logic [3:0] EXP_AND  = 4'b1000;
    localparam logic [3:0] EXP_OR   = 4'b1110;
    localparam logic [3:0] EXP_XOR  = 4'b0110;
    localparam logic [3:0] EXP_XNOR = 4'b1001;
    localparam logic [3:0] EXP_NAND = 4'b0111;
    localparam logic [3:0] EXP_NOR  = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_NOR;
    endfunction

    function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_alu.sv
// rtl/gate_alu.sv - combinational two-input gate with 3-bit op select
module gate_alu
    import gate_pkg::*;
(
    input  logic [2:0] op,
    input  logic       in1,
    input  logic       in2,
    output logic       y
);

    assign y = gate_eval(op, in1, in2);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps a shared gate through all four input vectors
// and compares the captured truth table against an expected one.
module gate_sweep_ctrl
    import gate_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [3:0] expected,
    output logic       gate_in1,
    output logic       gate_in2,
    output logic [2:0] gate_op,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_q,
    output logic       pass
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    sweep_state_t state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [3:0]   exp_q, exp_d;
    logic [3:0]   table_d;
    logic         pass_d;
    logic [1:0]   idx_q, idx_d;
    logic [3:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            exp_q   <= 4'd0;
            table_q <= 4'd0;
            pass    <= 1'b0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            pass    <= pass_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        exp_d    = exp_q;
        table_d  = table_q;
        pass_d   = pass;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;
        gate_in1 = 1'b0;
        gate_in2 = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    table_d = 4'd0;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    // Reserved ops finish immediately and leave gate_op untouched.
                    if (op_is_legal(op)) begin
                        op_d    = op;
                        exp_d   = expected;
                        state_d = ST_APPLY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_APPLY: begin
                busy     = 1'b1;
                gate_in1 = idx_q[1];
                gate_in2 = idx_q[0];
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                busy           = 1'b1;
                gate_in1       = idx_q[1];
                gate_in2       = idx_q[0];
                table_d[idx_q] = gate_out;
                cnt_d          = 4'd0;
                // Compare with the just-completed table so pass is valid alongside done.
                if (idx_q == 2'd3) begin
                    pass_d  = (table_d == exp_q);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gate_op = op_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - scoreboard bench for gate_sweep_ctrl at SETTLE=1 and SETTLE=3
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [2:0] op_sel = 3'd0;
    logic [3:0] exp_sel = 4'd0;

    logic       gi1_a, gi2_a, gout_a, busy_a, done_a, pass_a;
    logic [2:0] gop_a;
    logic [3:0] tbl_a;
    logic       gi1_b, gi2_b, gout_b, busy_b, done_b, pass_b;
    logic [2:0] gop_b;
    logic [3:0] tbl_b;

    gate_sweep_ctrl #(.SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .op(op_sel), .expected(exp_sel),
        .gate_in1(gi1_a), .gate_in2(gi2_a), .gate_op(gop_a), .gate_out(gout_a),
        .busy(busy_a), .done(done_a), .table_q(tbl_a), .pass(pass_a)
    );
    gate_alu u_gate_a (.op(gop_a), .in1(gi1_a), .in2(gi2_a), .y(gout_a));

    gate_sweep_ctrl #(.SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .op(op_sel), .expected(exp_sel),
        .gate_in1(gi1_b), .gate_in2(gi2_b), .gate_op(gop_b), .gate_out(gout_b),
        .busy(busy_b), .done(done_b), .table_q(tbl_b), .pass(pass_b)
    );
    gate_alu u_gate_b (.op(gop_b), .in1(gi1_b), .in2(gi2_b), .y(gout_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] tbl;
        logic       pass;
        int         cyc;
        logic [7:0] seq;
        int         nvec;
        int         nbusy;
    } entry_t;

    entry_t q_a[$];
    entry_t q_b[$];
    int checks = 0;
    int failures = 0;

    logic [3:0] all_tbl [0:5] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b0111, 4'b0001};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input string tag, input entry_t e, input logic [3:0] tbl,
                               input logic p, input logic [7:0] seq, input int nvec, input int nbusy);
        chk({tag, "_table"}, tbl, e.tbl);
        chk({tag, "_pass"}, p, e.pass);
        chk({tag, "_done_cycle"}, cyc, e.cyc);
        chk({tag, "_vector_count"}, nvec, e.nvec);
        chk({tag, "_vector_order"}, seq, e.seq);
        chk({tag, "_busy_cycles"}, nbusy, e.nbusy);
    endtask

    logic [1:0] last_a, last_b;
    logic [7:0] seq_a = 8'd0, seq_b = 8'd0;
    int nvec_a = 0, nvec_b = 0, nbusy_a = 0, nbusy_b = 0;

    always @(negedge clk) begin
        entry_t e;
        if (rst) begin
            seq_a = 8'd0; nvec_a = 0; nbusy_a = 0;
        end else begin
            if (busy_a) begin
                nbusy_a++;
                if (nvec_a == 0 || {gi1_a, gi2_a} != last_a) begin
                    last_a = {gi1_a, gi2_a};
                    seq_a  = {seq_a[5:0], last_a};
                    nvec_a++;
                end
            end
            if (done_a) begin
                if (q_a.size() == 0) chk("a_unexpected_done_queue", q_a.size(), 1);
                else begin
                    e = q_a.pop_front();
                    check_entry("a", e, tbl_a, pass_a, seq_a, nvec_a, nbusy_a);
                end
                seq_a = 8'd0; nvec_a = 0; nbusy_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        entry_t e;
        if (rst) begin
            seq_b = 8'd0; nvec_b = 0; nbusy_b = 0;
        end else begin
            if (busy_b) begin
                nbusy_b++;
                if (nvec_b == 0 || {gi1_b, gi2_b} != last_b) begin
                    last_b = {gi1_b, gi2_b};
                    seq_b  = {seq_b[5:0], last_b};
                    nvec_b++;
                end
            end
            if (done_b) begin
                if (q_b.size() == 0) chk("b_unexpected_done_queue", q_b.size(), 1);
                else begin
                    e = q_b.pop_front();
                    check_entry("b", e, tbl_b, pass_b, seq_b, nvec_b, nbusy_b);
                end
                seq_b = 8'd0; nvec_b = 0; nbusy_b = 0;
            end
        end
    end

    // Drive one start pulse; the expected response is queued for the monitor.
    task automatic issue(input bit on_b, input logic [2:0] o, input logic [3:0] e,
                         input logic [3:0] tbl, input logic p, input bit push);
        entry_t ent;
        int s;
        s = on_b ? 3 : 1;
        @(negedge clk);
        op_sel = o;
        exp_sel = e;
        if (on_b) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (push) begin
            ent.tbl  = tbl;
            ent.pass = p;
            if (o > 3'd5) begin
                ent.cyc = cyc; ent.seq = 8'h00; ent.nvec = 0; ent.nbusy = 0;
            end else begin
                ent.cyc = cyc + 4 * (s + 1); ent.seq = 8'h1B; ent.nvec = 4; ent.nbusy = 4 * (s + 1);
            end
            if (on_b) q_b.push_back(ent);
            else q_a.push_back(ent);
        end
    endtask

    task automatic wait_done(input bit on_b);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = on_b ? done_b : done_a;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done in 300 cycles expected a done pulse (dut %s)", on_b ? "b" : "a");
        end
        @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", busy_a, 1'b0);
        chk("reset_done", done_a, 1'b0);
        chk("reset_table", tbl_a, 4'd0);
        chk("reset_pass", pass_a, 1'b0);
        chk("reset_gate_in", {gi1_a, gi2_a}, 2'b00);
        chk("reset_gate_op", gop_a, 3'd0);
        chk("reset_busy_b", busy_b, 1'b0);

        // XNOR matching, then the table must hold after done.
        issue(0, 3'd3, 4'b1001, 4'b1001, 1'b1, 1'b1);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        chk("table_hold", tbl_a, 4'b1001);
        chk("pass_hold", pass_a, 1'b1);

        // AND against the XNOR table: mismatch.
        issue(0, 3'd0, 4'b1001, 4'b1000, 1'b0, 1'b1);
        wait_done(0);

        // All legal ops back-to-back, each accept in the cycle after done.
        for (int i = 0; i < 6; i++) begin
            issue(0, 3'(i), all_tbl[i], all_tbl[i], 1'b1, 1'b1);
            wait_done(0);
        end

        // Start re-asserted with different op/expected in cycles 2-5 must be ignored.
        issue(0, 3'd1, 4'b1110, 4'b1110, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        start_a = 1'b1;
        op_sel = 3'd0;
        exp_sel = 4'b0000;
        repeat (4) @(posedge clk);
        #1;
        start_a = 1'b0;
        wait_done(0);
        repeat (12) @(posedge clk);

        // NAND sweep reset in cycle 4.
        issue(0, 3'd4, 4'b0111, 4'b0111, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy_a, 1'b1);
        chk("pre_reset_table", tbl_a, 4'b0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_reset_busy", busy_a, 1'b0);
        chk("mid_reset_done", done_a, 1'b0);
        chk("mid_reset_table", tbl_a, 4'd0);
        chk("mid_reset_gate_in", {gi1_a, gi2_a}, 2'b00);
        chk("mid_reset_gate_op", gop_a, 3'd0);
        repeat (12) @(posedge clk);
        issue(0, 3'd2, 4'b0110, 4'b0110, 1'b1, 1'b1);
        wait_done(0);

        // Reserved op: immediate done, table cleared, gate_op kept.
        issue(0, 3'd7, 4'b1111, 4'b0000, 1'b0, 1'b1);
        wait_done(0);
        #1;
        chk("reserved_gate_op_held", gop_a, 3'd2);

        // SETTLE=3 instance.
        issue(1, 3'd2, 4'b0110, 4'b0110, 1'b1, 1'b1);
        wait_done(1);
        repeat (5) @(posedge clk);

        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
